// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain lines via pull-low enables; PS2_TX_TIMEOUT_EN adds a watchdog.
// Busy from accept+1 until the done/err cycle; pin clock fall reaches ps2_dat_oe in 3 clk; tx_valid is held off while busy.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_DATA,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [9:0]       shift_q, shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic             dat_oe_q, dat_oe_d;
   logic             nack_q, nack_d;
   logic             clk_s1_q, clk_s2_q, clk_prev_q;
   logic             dat_s1_q, dat_s2_q;
   logic             clk_fall;
   logic             timeout;

   assign clk_fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   // Held at zero until REQ, so the count is cycles since REQ entry.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == S_IDLE || state_q == S_INHIBIT) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LIMIT) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign timeout = (wd_cnt_q == WD_LIMIT) &&
                    (state_q == S_DATA || state_q == S_ACK || state_q == S_WAIT_IDLE);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      inh_cnt_d  = inh_cnt_q;
      dat_oe_d   = dat_oe_q;
      nack_d     = nack_q;
      tx_ready   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            if (tx_valid) begin
               shift_d   = {1'b1, ~^tx_data, tx_data};
               inh_cnt_d = '0;
               dat_oe_d  = 1'b0;
               nack_d    = 1'b0;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (inh_cnt_q == INH_LAST) begin
               ps2_dat_oe = 1'b1;
               state_d    = S_REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         S_REQ: begin
            ps2_dat_oe = 1'b1;
            dat_oe_d   = 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
         end
         S_DATA: begin
            ps2_dat_oe = dat_oe_q;
            if (clk_fall) begin
               // Ten edges shift out data, parity and stop; the eleventh carries the device ACK.
               if (bit_cnt_q == 4'd10) begin
                  nack_d   = dat_s2_q;
                  dat_oe_d = 1'b0;
                  state_d  = S_ACK;
               end else begin
                  dat_oe_d  = ~shift_q[0];
                  shift_d   = {1'b0, shift_q[9:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_ACK: begin
            state_d = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (clk_s2_q && dat_s2_q) begin
               done    = ~nack_q;
               err     = nack_q;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (timeout) begin
         ps2_clk_oe = 1'b0;
         ps2_dat_oe = 1'b0;
         done       = 1'b0;
         err        = 1'b1;
         dat_oe_d   = 1'b0;
         state_d    = S_IDLE;
      end
   end

   // Synchronizers reset high so an idle bus never looks like a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         inh_cnt_q  <= '0;
         dat_oe_q   <= 1'b0;
         nack_q     <= 1'b0;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         inh_cnt_q  <= inh_cnt_d;
         dat_oe_q   <= dat_oe_d;
         nack_q     <= nack_d;
         clk_s1_q   <= ps2_clk_i;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_i;
         dat_s2_q   <= dat_s1_q;
      end
   end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte from the FPGA to the attached keyboard, for example 0xED (set LEDs) or 0xFF (reset). It sits beside the existing PS/2 keyboard receiver and shares the same two open-drain lines. It drives each line only through an output-enable (pull-low) signal; the top level builds the tri-state buffers. While a transfer is in progress, `busy` tells the receiver to discard line activity.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000, number of clk cycles the PS/2 clock is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000, watchdog limit in clk cycles, counted from REQ entry (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte sent and acknowledged.
- err  out  1  one-cycle pulse: NACK or timeout; never coincident with done.
- ps2_clk_i  in  1  raw PS2_CLK pin level.
- ps2_dat_i  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.

## Operation
- **Input conditioning:** ps2_clk_i and ps2_dat_i each pass through a 2-FF synchronizer. A falling edge is detected as previous synced clock = 1 and current = 0.
- **Frame:** 10-bit shift register = {stop=1, parity, data[7:0]}, sent LSB first. parity = ~^tx_data (odd parity).
- **States:**
  - **IDLE:** both oe = 0. On accept, latch tx_data and build the frame, then go to INHIBIT. Falling edges in IDLE are ignored.
  - **INHIBIT:** ps2_clk_oe = 1 for INHIBIT_CYCLES cycles. ps2_dat_oe = 1 in the final cycle (start bit), then go to REQ.
  - **REQ:** ps2_clk_oe = 0, ps2_dat_oe = 1. Clear the bit counter and go to DATA.
  - **DATA:** on each falling edge, ps2_dat_oe = ~shift[0], then shift right and increment the counter.
    - Edges 1–8 send data bits, edge 9 sends parity, edge 10 sends stop (released).
    - The 11th falling edge moves to ACK.
  - **ACK:** sample the synced data line in the cycle the 11th edge is detected. Low = ACK, high = NACK. Go to WAIT_IDLE.
  - **WAIT_IDLE:** wait until the synced clock and data lines are both high. Then go to IDLE, pulsing done on ACK or err on NACK.
- **Back-to-back requests:** tx_valid while busy is not accepted. Upstream holds it, and it is accepted in the first IDLE cycle after done/err.
- **Reset mid-transfer:** both lines are released immediately (asynchronously), state goes to IDLE, and the latched byte is discarded. No done/err pulse is produced.

## Timing
- **Reset values:** tx_ready = 1, busy = 0, done = 0, err = 0, ps2_clk_oe = 0, ps2_dat_oe = 0. The frame register and all counters are cleared.
- **Accept to INHIBIT:** the accept cycle is N. ps2_clk_oe and busy rise at N+1, and tx_ready falls at N+1.
- **Pin edge to action:** 3 clk cycles from a pin falling edge to the ps2_dat_oe update (2-FF sync plus edge register). This is far inside the device's clock-low half period (≥ 30 µs).
- **Counter widths:** sized by $clog2 of their parameter. The bit counter is 4 bits.
- **Total transfer time:** INHIBIT_CYCLES + 1 REQ cycle + 11 device clocks + the idle wait.

## Configuration
- **PS2_TX_TIMEOUT_EN defined:**
  - A watchdog counts from REQ entry.
  - At TIMEOUT_CYCLES, in any of DATA, ACK or WAIT_IDLE: both oe = 0, err pulses for one cycle, state goes to IDLE.
  - The counter resets on every new accept.
- **PS2_TX_TIMEOUT_EN undefined:**
  - No watchdog logic is built.
  - A silent device leaves the block busy until reset.

## Test plan
- **0xED with ACK** (bench INHIBIT_CYCLES = 50, device model clocks at 12 kHz): clk held low 50 cycles; data bits on the wire 1,0,1,1,0,1,1,1; parity 1; stop released; device ACK → one done pulse, err = 0, tx_ready back to 1.
- **0x01 parity check:** parity bit on the wire = 0 (a single one bit). **0xFF:** parity bit = 1.
- **NACK:** device leaves data high at the 11th falling edge → err pulses once, done stays 0, both oe = 0 afterwards.
- **Timeout** (PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES = 1000, device never clocks): err pulses exactly 1000 cycles after REQ entry and both lines are released. With the macro undefined, busy remains 1 for 5000 cycles.
- **Reset mid-byte:** assert reset after the 4th falling edge → ps2_clk_oe = ps2_dat_oe = 0 with no clk edge needed, busy = 0, no done or err pulse. A following 0xFF transfers correctly.
- **Held tx_valid:** tx_valid held with 0xF4 during an active 0xED transfer → 0xF4 is accepted in the cycle after done, and the wire carries 0xED then 0xF4 with no corruption.
